// File: rtl/id_stage_seq_pkg.sv
// Shared decode constants for the RV32I ID stage: immediate-type codes and base opcodes.
// Build option: ID_SKID_EN enables the two-entry skid buffer in id_stage_seq.
package id_stage_seq_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMM_TYPE_W = 3;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned OPC_W      = 7;

  typedef enum logic [IMM_TYPE_W-1:0] {
    ITYPE = 3'd0,
    STYPE = 3'd1,
    BTYPE = 3'd2,
    UTYPE = 3'd3,
    JTYPE = 3'd4,
    RTYPE = 3'd5
  } imm_type_e;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/id_stage_seq_imm_ext.sv
// RV32I immediate extender: reassembles and sign-extends the immediate for a given type.
module imm_ext
  import id_stage_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     inst_i,
  input  imm_type_e       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_i)
      ITYPE:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      STYPE:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      BTYPE:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      UTYPE:   imm32 = {inst_i[31:12], 12'h000};
      JTYPE:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_seq_imm_type_decode.sv
// Combinational RV32I opcode classifier: opcode -> immediate type plus illegal flag.
module imm_type_decode
  import id_stage_seq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output imm_type_e        imm_type_o,
  output logic             illegal_o
);

  always_comb begin
    imm_type_o = RTYPE;
    illegal_o  = 1'b0;
    case (opcode_i)
      OPC_OP:                          imm_type_o = RTYPE;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  imm_type_o = ITYPE;
      OPC_STORE:                       imm_type_o = STYPE;
      OPC_BRANCH:                      imm_type_o = BTYPE;
      OPC_LUI, OPC_AUIPC:              imm_type_o = UTYPE;
      OPC_JAL:                         imm_type_o = JTYPE;
      default: begin
        imm_type_o = RTYPE;
        illegal_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_seq.sv
// ID stage sequencer: decodes fetched instructions into a buffered ID/EX bundle.
// Build option: ID_SKID_EN adds a skid entry and a registered in_ready; otherwise main register only.
module id_stage_seq
  import id_stage_seq_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMM_TYPE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [XLEN-1:0]       out_pc,
  output logic [IMM_TYPE_W-1:0] out_imm_type,
  output logic [XLEN-1:0]       out_imm,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [31:0]           inst;
    logic [XLEN-1:0]       pc;
    logic [IMM_TYPE_W-1:0] imm_type;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{
    inst: '0, pc: '0, imm_type: IMM_TYPE_W'(RTYPE), imm: '0, illegal: 1'b0
  };

  imm_type_e       dec_type;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  entry_t          in_entry;

  imm_type_decode u_imm_type_decode (
    .opcode_i   (in_inst[6:0]),
    .imm_type_o (dec_type),
    .illegal_o  (dec_illegal)
  );

  imm_ext #(.XLEN(XLEN)) u_imm_ext (
    .inst_i     (in_inst[31:7]),
    .imm_type_i (dec_type),
    .imm_o      (dec_imm)
  );

  always_comb begin
    in_entry.inst     = in_inst;
    in_entry.pc       = in_pc;
    in_entry.imm_type = IMM_TYPE_W'(dec_type);
    in_entry.imm      = dec_imm;
    in_entry.illegal  = dec_illegal;
  end

  entry_t main_q, main_d;
  logic   main_valid_q, main_valid_d;
  logic   accept, issue;

`ifdef ID_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  assign in_ready = in_ready_q;
`else
  assign in_ready = !main_valid_q || out_ready;
`endif

  assign accept = in_valid && in_ready;
  assign issue  = main_valid_q && out_ready;

  // Next-state: flush wins; an issuing main refills from skid first, then from the input.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
`ifdef ID_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
`ifdef ID_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (issue) begin
`ifdef ID_SKID_EN
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else
`endif
      if (accept) begin
        main_d = in_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
`ifdef ID_SKID_EN
      if (main_valid_q) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end else
`endif
      begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end
    end
`ifdef ID_SKID_EN
    in_ready_d = !skid_valid_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= ENTRY_RST;
      main_valid_q <= 1'b0;
`ifdef ID_SKID_EN
      skid_q       <= ENTRY_RST;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
`ifdef ID_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign out_valid    = main_valid_q;
  assign out_inst     = main_q.inst;
  assign out_pc       = main_q.pc;
  assign out_imm_type = main_q.imm_type;
  assign out_imm      = main_q.imm;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_id_stage_seq.sv
// Randomized and directed bench for id_stage_seq against a queue-based decode/FIFO model.
module tb_id_stage_seq;
  import id_stage_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_inst, out_pc, out_imm;
  logic [2:0]  out_imm_type;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  id_stage_seq #(.XLEN(32), .IMM_TYPE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm_type(out_imm_type), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  // Reference decode built from field arithmetic rather than bit concatenation.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int   hi;
    logic [6:0] op;
    e.inst = inst; e.pc = pc; e.ill = 1'b0; e.imm = 32'h0; e.ty = RTYPE;
    op = inst[6:0];
    case (op)
      7'b0110011: begin e.ty = RTYPE; e.imm = 32'h0; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e.ty = ITYPE; hi = $signed(inst) >>> 20; e.imm = 32'(hi);
      end
      7'b0100011: begin
        e.ty = STYPE; hi = $signed(inst) >>> 25;
        e.imm = 32'(hi * 32 + int'(inst[11:7]));
      end
      7'b1100011: begin
        e.ty = BTYPE; hi = $signed(inst) >>> 31;
        e.imm = 32'(hi * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2);
      end
      7'b0110111, 7'b0010111: begin e.ty = UTYPE; e.imm = inst & 32'hFFFF_F000; end
      7'b1101111: begin
        e.ty = JTYPE; hi = $signed(inst) >>> 31;
        e.imm = 32'(hi * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2);
      end
      default: begin e.ty = RTYPE; e.ill = 1'b1; e.imm = 32'h0; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_inst", out_inst, q[0].inst);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm_type", 32'(out_imm_type), 32'(q[0].ty));
      chk("out_imm", out_imm, q[0].imm);
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic exp_rdy, acc, iss;
    in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
`ifdef ID_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    iss = (q.size() > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(model(inst, pc));
    end
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    chk({tag, "_out_inst"}, out_inst, 32'h0);
    chk({tag, "_out_pc"}, out_pc, 32'h0);
    chk({tag, "_out_imm"}, out_imm, 32'h0);
    chk({tag, "_out_illegal"}, 32'(out_illegal), 32'h0);
    chk({tag, "_out_imm_type"}, 32'(out_imm_type), 32'(RTYPE));
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001011};

  task automatic rand_cycles(input int n);
    logic [31:0] r, inst;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      inst = {r[31:7], ops[$urandom_range(0, 9)]};
      cycle(($urandom_range(0, 3) != 0), inst, $urandom(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Single ITYPE accept, visible one cycle later.
    cycle(1'b1, 32'hFFF0_0093, 32'h0, 1'b1, 1'b0);
    chk("itype_valid", 32'(out_valid), 32'h1);
    chk("itype_type", 32'(out_imm_type), 32'(ITYPE));
    chk("itype_imm", out_imm, 32'hFFFF_FFFF);
    chk("itype_illegal", 32'(out_illegal), 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back stream at full throughput.
    cycle(1'b1, 32'h0011_2623, 32'h4, 1'b1, 1'b0);
    chk("stream_s_imm", out_imm, 32'h0000_000C);
    chk("stream_s_type", 32'(out_imm_type), 32'(STYPE));
    cycle(1'b1, 32'h1234_52B7, 32'h8, 1'b1, 1'b0);
    chk("stream_u_imm", out_imm, 32'h1234_5000);
    chk("stream_u_type", 32'(out_imm_type), 32'(UTYPE));
    cycle(1'b1, 32'hFFDF_F06F, 32'hC, 1'b1, 1'b0);
    chk("stream_j_imm", out_imm, 32'hFFFF_FFFC);
    chk("stream_j_type", 32'(out_imm_type), 32'(JTYPE));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure for three cycles, then release and drain.
    cycle(1'b1, 32'h0010_0093, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0113, 32'h14, 1'b0, 1'b0);
    cycle(1'b1, 32'h0030_0193, 32'h18, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with buffer full and an incoming instruction.
    cycle(1'b1, 32'h0040_0213, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 32'h0050_0293, 32'h24, 1'b0, 1'b0);
    cycle(1'b1, 32'h0060_0313, 32'h28, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Illegal opcode passes through as RTYPE with zero immediate.
    cycle(1'b1, 32'h0000_000B, 32'h30, 1'b1, 1'b0);
    chk("illegal_flag", 32'(out_illegal), 32'h1);
    chk("illegal_type", 32'(out_imm_type), 32'(RTYPE));
    chk("illegal_imm", out_imm, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    rand_cycles(400);

    // Asynchronous reset mid-stream, sampled before any clock edge.
    cycle(1'b1, 32'h0070_0393, 32'h40, 1'b0, 1'b0);
    cycle(1'b1, 32'h0080_0413, 32'h44, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    q.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_cycles(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_seq.md
# id_stage_seq

Decode-stage sequencer for the RV32I core. It accepts fetched instructions from IF over a valid/ready handshake and classifies each opcode into an immediate type. It drives the immediate extender and registers the instruction, PC, immediate type, extended immediate and an illegal flag into a buffered ID/EX bundle with its own valid/ready handshake. It sits between the IF pipeline register and the EX stage, and absorbs EX back-pressure and branch flushes.

## Interface
Parameters:
- XLEN, 32, datapath width for PC and immediate
- IMM_TYPE_W, 3, width of the immediate-type code (matches `Parameters.v`)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held and incoming entries
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  ID can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  bundle valid to EX
- out_ready  in  1  EX accepts bundle
- out_inst  out  32  registered instruction
- out_pc  out  XLEN  registered PC
- out_imm_type  out  IMM_TYPE_W  `ITYPE`/`STYPE`/`BTYPE`/`UTYPE`/`JTYPE`/`RTYPE`
- out_imm  out  XLEN  extended immediate
- out_illegal  out  1  opcode not in RV32I base map

## Operation
- Opcode classification on inst[6:0]:
  - 0110011 -> RTYPE
  - 0010011, 0000011, 1100111 -> ITYPE
  - 0100011 -> STYPE
  - 1100011 -> BTYPE
  - 0110111, 0010111 -> UTYPE
  - 1101111 -> JTYPE
  - All others -> RTYPE, illegal=1.
- Immediate is produced combinationally from inst[31:7] and the decoded type before capture. RTYPE and illegal instructions produce imm = 0.
- Accept: in_valid && in_ready. Issue: out_valid && out_ready.
- Buffering is two entries: a main register, which drives out_*, and a skid register.
  - Accept while main is empty, or while main is issuing: the entry goes to main.
  - Accept while main is held (out_valid && !out_ready): the entry goes to skid.
  - Main issues while skid is full: skid moves to main on the same edge.
- in_ready = !skid_valid. It is a registered signal, with no combinational path from out_ready.
- Order is strictly FIFO. No entry is duplicated or dropped, except by flush.
- flush has priority over every other event:
  - At the next edge, main_valid and skid_valid clear.
  - An entry accepted in the flush cycle is discarded.
  - An issue in the flush cycle still counts as taken by EX.
- Illegal instructions are passed through as normal bundles. EX/CSR logic acts on out_illegal.

## Timing
- Reset: out_valid=0, in_ready=1, and out_inst, out_pc, out_imm, out_illegal are 0. out_imm_type = RTYPE. Skid is empty.
- Latency: accept at edge N -> out_valid and data visible after edge N (one cycle) when main is empty.
- Throughput: one instruction per cycle while out_ready=1.
- Full: both entries valid -> in_ready=0 from the following cycle. It returns to 1 the cycle after the first issue.
- Simultaneous accept and issue with skid full is impossible, because in_ready=0.
- Simultaneous accept and issue with skid empty: the new entry replaces main and out_valid stays 1.
- Mid-operation reset clears all state immediately, with no edge required.
- Output data holds stable while out_valid && !out_ready.

## Configuration
- ID_SKID_EN defined: two-entry buffer as above, with a registered in_ready.
- ID_SKID_EN undefined:
  - Main register only; in_ready = !out_valid || out_ready (combinational).
  - Latency and flush behaviour are unchanged.
  - Full occurs after one held entry.

## Structure
- The immediate-type codes (`ITYPE`, `STYPE`, `BTYPE`, `UTYPE`, `JTYPE`, `RTYPE`) and the RV32I opcode constants belong in shared `Parameters.v`. No local redefinition is allowed.
- One sub-module, `imm_type_decode`: combinational opcode -> {imm_type, illegal}. The existing immediate extender is instantiated beside it.
- The buffer/handshake logic lives in the top module.

## Test plan
- Reset, then single accept of 0xFFF00093 at pc 0x0 -> one cycle later out_valid=1, imm_type=ITYPE, imm=0xFFFFFFFF, illegal=0.
- Back-to-back stream with out_ready=1:
  - Inputs: 0x00112623, 0x123452B7, 0xFFDFF06F.
  - Required outputs, one per cycle in order: STYPE imm 0x0000000C; UTYPE imm 0x12345000; JTYPE imm 0xFFFFFFFC.
- Back-pressure: out_ready=0 for 3 cycles during a stream.
  - in_ready drops after 2 accepts and the outputs hold stable.
  - On release, both entries issue in order with no loss or duplication.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and no stale entry ever appears on out_*.
- 0x0000000B -> out_illegal=1, imm_type=RTYPE, imm=0. Assert rst_n low mid-stream -> outputs reach reset values asynchronously.
- Repeat the back-pressure and flush scenarios with ID_SKID_EN undefined -> in_ready follows !out_valid || out_ready in the same cycle.
